conv_b1_pointwise: RTL and testbench
====================================

Name: conv_b1_pointwise

Overview:
- Consumes the eight 7-bit signed weights and the one-cycle `new_weight_val` pulse produced by the B1 weight-control stage.
- Applies them as a pointwise (1-tap, 1-in/8-out channel) convolution to a streamed ECG sample sequence.
- Datapath per channel: round-shift requantisation, ReLU, then saturation.
- Sits between the ECG sample front end and the B2 layer; also tags frame boundaries for downstream pooling.

Parameters:
- IN_W, 8, signed input sample width
- W_W, 7, signed weight width
- OUT_W, 8, signed output width per channel
- SHIFT, 6, requantisation right-shift (must be >=1)
- FRAME_LEN, 1250, samples per ECG frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- w_00,w_10,w_20,w_30,w_40,w_50,w_60,w_70  in  W_W each  signed weights, channel 0..7
- new_weight_val  in  1  one-cycle pulse: weight inputs valid this cycle
- din  in  IN_W  signed ECG sample
- din_val  in  1  sample valid
- din_ready  out  1  block accepts sample (transfer = din_val && din_ready)
- dout  out  8*OUT_W  channel k in bits [k*OUT_W +: OUT_W], signed, always >= 0
- dout_val  out  1  dout valid, one-cycle per result
- dout_last  out  1  asserted with dout_val on the last result of a frame

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` asynchronous, active-low. All state and outputs are cleared on assertion, including mid-frame. After release, the state machine is in WAIT_W.
- Reset values: din_ready=0, dout=0, dout_val=0, dout_last=0, shadow/active weights=0, pending=0, sample counter=0, pipeline valids=0.
- Weight capture: on any cycle with `new_weight_val`=1, the eight inputs are copied into shadow registers.
- FSM, two states:
  - WAIT_W: din_ready=0. When `new_weight_val`=1, load the active registers directly from the weight inputs (same edge) and go to RUN. No pending flag is set.
  - RUN: din_ready=1.
    - `new_weight_val` in RUN sets `pending`.
    - At a frame boundary (sample counter==0 and a transfer occurs), if `pending`=1, active<=shadow before that sample is multiplied, and `pending` clears.
    - If `new_weight_val` and the boundary transfer coincide, the new weights apply to that sample and `pending` stays 0.
    - The block never returns to WAIT_W except by reset.
- Sample counter: increments per accepted sample, 0..FRAME_LEN-1, and wraps to 0 after FRAME_LEN-1. The last-flag travels down the pipeline with the sample.
- Pipeline, fixed latency 3 cycles from the accepting edge to dout_val. There is no backpressure from downstream.
  - S1: register din, last-flag, valid.
  - S2: eight signed products p_k = x * w_k, width IN_W+W_W (15 bits).
  - S3, per channel:
    - r = (p_k + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
    - If r<0, output 0.
    - Else if r > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1.
    - Else output r.
- Throughput: one sample per cycle. dout_val mirrors accepted din_val delayed by 3; gaps in din_val produce equal gaps in dout_val.
- dout holds its last value when dout_val=0.

Decomposition:
- Shared package: IN_W/W_W/OUT_W defaults, FSM state encodings (WAIT_W=0, RUN=1), FRAME_LEN constant, and the product width (IN_W+W_W).
- One natural sub-module: `requant_relu_sat`, combinational, instantiated 8x. It takes one product plus SHIFT/OUT_W and returns the rounded, ReLU'd, saturated value.

Test Plan:
- Reset release, din_val=1 held, no weight pulse -> din_ready stays 0, dout_val never asserts; then pulse with w_00=10 -> din_ready=1 next cycle.
- w_00=10, w_10=-10, din=50 -> 3 cycles later dout ch0=8 ((500+32)>>6), ch1=0 (ReLU).
- w_00=-64, din=-128 -> product 8192, r=128 -> ch0 saturates to 127; w_00=63, din=127 -> ch0=125.
- Stream FRAME_LEN+2 back-to-back samples -> dout_last exactly on output #1250 only, counter wraps, output #1251 has dout_last=0.
- Weight pulse at sample 600 with w_00 changing 10->20, din=50 constant -> outputs 601..1250 still ch0=8; output 1251 onward ch0=16 (1032>>6).
- Assert rst_n low mid-frame with 3 samples in flight -> dout_val=0 immediately and no stale result after release; din_ready=0 until a new weight pulse arrives.

Source files
------------

// File: rtl/conv_b1_pointwise_pkg.sv
// Shared widths, frame length and FSM encoding for the B1 pointwise convolution.
package conv_b1_pointwise_pkg;

  localparam int IN_W      = 8;
  localparam int W_W       = 7;
  localparam int OUT_W     = 8;
  localparam int SHIFT     = 6;
  localparam int FRAME_LEN = 1250;
  localparam int N_CH      = 8;
  localparam int PROD_W    = IN_W + W_W;

  typedef enum logic {
    WAIT_W = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/conv_b1_pointwise_if.sv
// Weight, sample and result bundle of the B1 pointwise convolution.
// Handshake: a sample moves on a cycle with din_val && din_ready; din_ready
// never depends on din_val. dout_val is a one-cycle pulse per result with no
// backpressure, and new_weight_val is a one-cycle pulse qualifying w_00..w_70.
interface conv_b1_pointwise_if
  import conv_b1_pointwise_pkg::*;
#(
  parameter int P_IN_W  = IN_W,
  parameter int P_W_W   = W_W,
  parameter int P_OUT_W = OUT_W
);

  logic signed [P_W_W-1:0]  w_00, w_10, w_20, w_30, w_40, w_50, w_60, w_70;
  logic                     new_weight_val;
  logic signed [P_IN_W-1:0] din;
  logic                     din_val;
  logic                     din_ready;
  logic [8*P_OUT_W-1:0]     dout;
  logic                     dout_val;
  logic                     dout_last;

  modport master (
    output w_00, w_10, w_20, w_30, w_40, w_50, w_60, w_70,
    output new_weight_val, din, din_val,
    input  din_ready, dout, dout_val, dout_last
  );

  modport slave (
    input  w_00, w_10, w_20, w_30, w_40, w_50, w_60, w_70,
    input  new_weight_val, din, din_val,
    output din_ready, dout, dout_val, dout_last
  );

endinterface

// File: rtl/conv_b1_pointwise_requant_relu_sat.sv
// Round-half-up arithmetic shift of one product, then ReLU and clamp to the
// largest positive OW-bit signed value.
module requant_relu_sat #(
  parameter int PW    = 15,
  parameter int SHIFT = 6,
  parameter int OW    = 8
) (
  input  logic signed [PW-1:0] p,
  output logic [OW-1:0]        q
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [PW:0] RND  = (PW+1)'(1) <<< (SHIFT-1);
  localparam logic signed [PW:0] QMAX = (PW+1)'((1 << (OW-1)) - 1);

  logic signed [PW:0] sum;
  logic signed [PW:0] r;

  always_comb begin
    sum = $signed({p[PW-1], p}) + RND;
    r   = sum >>> SHIFT;
    if (r < 0) begin
      q = '0;
    end else if (r > QMAX) begin
      q = QMAX[OW-1:0];
    end else begin
      q = r[OW-1:0];
    end
  end

endmodule

// File: rtl/conv_b1_pointwise.sv
// 1-in/8-out pointwise convolution over a framed ECG stream: weights switch
// only at frame boundaries, three-stage pipeline, frame-end tag on dout_last.
module conv_b1_pointwise
  import conv_b1_pointwise_pkg::*;
#(
  parameter int P_IN_W      = IN_W,
  parameter int P_W_W       = W_W,
  parameter int P_OUT_W     = OUT_W,
  parameter int P_SHIFT     = SHIFT,
  parameter int P_FRAME_LEN = FRAME_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_b1_pointwise_if.slave   bus,
  output state_t               state_dbg
);

  localparam int PW = P_IN_W + P_W_W;
  localparam int CW = $clog2(P_FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_FRAME_LEN - 1);

  logic signed [P_W_W-1:0] w_in     [N_CH];
  logic signed [P_W_W-1:0] w_shadow [N_CH];
  logic signed [P_W_W-1:0] w_act    [N_CH];

  state_t        state, state_nxt;
  logic          pending, pending_nxt;
  logic          load_in, load_shadow;
  logic          din_ready_c;
  logic          transfer, boundary;
  logic [CW-1:0] cnt;

  logic signed [P_IN_W-1:0] x1;
  logic                     v1, last1;
  logic signed [PW-1:0]     prod [N_CH];
  logic                     v2, last2;
  logic [8*P_OUT_W-1:0]     q_vec;
  logic [8*P_OUT_W-1:0]     dout_r;
  logic                     dout_val_r, dout_last_r;

  assign w_in[0] = bus.w_00;
  assign w_in[1] = bus.w_10;
  assign w_in[2] = bus.w_20;
  assign w_in[3] = bus.w_30;
  assign w_in[4] = bus.w_40;
  assign w_in[5] = bus.w_50;
  assign w_in[6] = bus.w_60;
  assign w_in[7] = bus.w_70;

  assign transfer = bus.din_val && (state == RUN);
  assign boundary = transfer && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_W;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    load_in     = 1'b0;
    load_shadow = 1'b0;
    din_ready_c = 1'b0;
    case (state)
      WAIT_W: begin
        if (bus.new_weight_val) begin
          load_in   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        din_ready_c = 1'b1;
        // A pulse landing on the boundary sample wins over an older pending set.
        if (boundary && bus.new_weight_val) begin
          load_in     = 1'b1;
          pending_nxt = 1'b0;
        end else if (boundary && pending) begin
          load_shadow = 1'b1;
          pending_nxt = 1'b0;
        end else if (bus.new_weight_val) begin
          pending_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cnt     <= '0;
      for (int k = 0; k < N_CH; k++) begin
        w_shadow[k] <= '0;
        w_act[k]    <= '0;
      end
    end else begin
      pending <= pending_nxt;
      if (transfer) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (bus.new_weight_val) w_shadow[k] <= w_in[k];
        if (load_in)            w_act[k]    <= w_in[k];
        else if (load_shadow)   w_act[k]    <= w_shadow[k];
      end
    end
  end

  // S1 sample register, S2 products against the weights now active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1    <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
      v2    <= 1'b0;
      last2 <= 1'b0;
      for (int k = 0; k < N_CH; k++) prod[k] <= '0;
    end else begin
      v1 <= transfer;
      if (transfer) begin
        x1    <= bus.din;
        last1 <= (cnt == CNT_LAST);
      end
      v2    <= v1;
      last2 <= last1;
      for (int k = 0; k < N_CH; k++) prod[k] <= PW'(x1) * PW'(w_act[k]);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    requant_relu_sat #(
      .PW   (PW),
      .SHIFT(P_SHIFT),
      .OW   (P_OUT_W)
    ) u_rq (
      .p(prod[k]),
      .q(q_vec[k*P_OUT_W +: P_OUT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r      <= '0;
      dout_val_r  <= 1'b0;
      dout_last_r <= 1'b0;
    end else begin
      dout_val_r  <= v2;
      dout_last_r <= v2 && last2;
      if (v2) dout_r <= q_vec;
    end
  end

  assign bus.din_ready = din_ready_c;
  assign bus.dout      = dout_r;
  assign bus.dout_val  = dout_val_r;
  assign bus.dout_last = dout_last_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_conv_b1_pointwise.sv
// Bench for conv_b1_pointwise: frame-level weight model with a per-cycle
// compare against an expected queue, plus hand-computed spot values.
module tb_conv_b1_pointwise;
  import conv_b1_pointwise_pkg::*;

  localparam int EW = 32 + 1 + 8*OUT_W;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  always #5 clk = ~clk;

  conv_b1_pointwise_if bus ();

  conv_b1_pointwise dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [EW-1:0] exp_q[$];
  int cyc = 0;
  int run = 0;
  int cnt_m = 0;
  int lw[8];
  int fw[8];

  function automatic logic [8*OUT_W-1:0] expect_out(input int x, input int w[8]);
    logic [8*OUT_W-1:0] v;
    int p, r;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      p = x * w[k];
      r = (p + (1 << (SHIFT-1))) >>> SHIFT;
      if (r < 0) r = 0;
      if (r > (1 << (OUT_W-1)) - 1) r = (1 << (OUT_W-1)) - 1;
      v[k*OUT_W +: OUT_W] = OUT_W'(r);
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run = 0;
      cnt_m = 0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin lw[k] = 0; fw[k] = 0; end
    end else begin
      cyc++;
      if (bus.new_weight_val) begin
        lw[0] = int'(bus.w_00); lw[1] = int'(bus.w_10);
        lw[2] = int'(bus.w_20); lw[3] = int'(bus.w_30);
        lw[4] = int'(bus.w_40); lw[5] = int'(bus.w_50);
        lw[6] = int'(bus.w_60); lw[7] = int'(bus.w_70);
      end
      if (run == 0) begin
        if (bus.new_weight_val) begin run = 1; fw = lw; end
      end else if (bus.din_val) begin
        // Weights in force for a frame are the most recent ones seen at its first sample.
        if (cnt_m == 0) fw = lw;
        exp_q.push_back({32'(cyc + 2), (cnt_m == FRAME_LEN - 1), expect_out(int'(bus.din), fw)});
        cnt_m = (cnt_m + 1) % FRAME_LEN;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      chk("rst_dout_val", bus.dout_val, 0);
      chk("rst_din_ready", bus.din_ready, 0);
    end else begin
      chk("din_ready", bus.din_ready, 64'(run));
      chk("state_run", state_dbg == RUN, 64'(run));
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == 32'(cyc)) begin
        e = exp_q.pop_front();
        chk("dout_val", bus.dout_val, 1);
        chk("dout", bus.dout, e[8*OUT_W-1:0]);
        chk("dout_last", bus.dout_last, e[8*OUT_W]);
      end else begin
        chk("idle_dout_val", bus.dout_val, 0);
        chk("idle_dout_last", bus.dout_last, 0);
      end
    end
  end

  // Output index tracking for frame-boundary spot checks.
  int out_idx = 0, last_cnt = 0, last_idx = 0, l1251 = 0;
  logic [63:0] cap601, cap1250, cap1251;
  always @(negedge clk) begin
    if (!rst_n) begin
      out_idx = 0; last_cnt = 0; last_idx = 0;
    end else if (bus.dout_val) begin
      out_idx++;
      if (bus.dout_last) begin last_cnt++; last_idx = out_idx; end
      if (out_idx == 601)  cap601  = bus.dout;
      if (out_idx == 1250) cap1250 = bus.dout;
      if (out_idx == 1251) begin cap1251 = bus.dout; l1251 = int'(bus.dout_last); end
    end
  end

  // ---------------- driver tasks ----------------
  logic signed [W_W-1:0] wv[8];
  logic signed [IN_W-1:0] tbl[8] = '{-128, 127, 0, 1, -1, 50, -100, 77};

  task automatic load_w();
    bus.w_00 = wv[0]; bus.w_10 = wv[1]; bus.w_20 = wv[2]; bus.w_30 = wv[3];
    bus.w_40 = wv[4]; bus.w_50 = wv[5]; bus.w_60 = wv[6]; bus.w_70 = wv[7];
  endtask

  task automatic do_reset();
    bus.new_weight_val = 0; bus.din_val = 0; bus.din = 0;
    @(negedge clk); #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pulse();
    @(negedge clk); load_w(); bus.new_weight_val = 1;
    @(negedge clk); bus.new_weight_val = 0;
  endtask

  task automatic probe(input logic signed [IN_W-1:0] x, input logic [7:0] e0, input logic [7:0] e1,
                       input string name);
    @(negedge clk); bus.din = x; bus.din_val = 1;
    @(negedge clk); bus.din_val = 0;
    repeat (2) @(negedge clk);
    chk({name, "_val"}, bus.dout_val, 1);
    chk({name, "_ch0"}, bus.dout[7:0], e0);
    chk({name, "_ch1"}, bus.dout[15:8], e1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int sent, i;
    wv = '{default: 0};
    load_w();
    bus.new_weight_val = 0; bus.din_val = 0; bus.din = 0;
    do_reset();

    // No weights yet: samples are refused.
    bus.din_val = 1; bus.din = 5;
    repeat (5) @(negedge clk);
    chk("no_w_ready", bus.din_ready, 0);
    chk("no_w_dout_val", bus.dout_val, 0);
    wv = '{10, -10, 0, 0, 0, 0, 0, 0};
    load_w(); bus.new_weight_val = 1; bus.din_val = 0;
    @(negedge clk); bus.new_weight_val = 0;
    chk("ready_after_w", bus.din_ready, 1);
    probe(50, 8, 0, "basic");

    do_reset();
    wv = '{-64, 0, 0, 0, 0, 0, 0, 0};
    pulse();
    probe(-128, 127, 0, "sat");

    do_reset();
    wv = '{63, 32, 0, 0, 0, 0, 0, 0};
    pulse();
    probe(127, 125, 64, "round");

    // Full frame plus two, with a mid-frame weight change held until the boundary.
    do_reset();
    wv = '{10, 20, -3, 7, 63, -64, 1, -1};
    pulse();
    for (int k = 0; k < FRAME_LEN + 2; k++) begin
      @(negedge clk);
      bus.din_val = 1; bus.din = 50;
      if (k == 599) begin wv[0] = 20; load_w(); bus.new_weight_val = 1; end
      else bus.new_weight_val = 0;
    end
    @(negedge clk); bus.din_val = 0; bus.new_weight_val = 0;
    repeat (4) @(negedge clk);
    chk("frame_last_count", 64'(last_cnt), 1);
    chk("frame_last_idx", 64'(last_idx), 1250);
    chk("out601_ch0", cap601[7:0], 8);
    chk("out1250_ch0", cap1250[7:0], 8);
    chk("out1251_ch0", cap1251[7:0], 16);
    chk("out1251_last", 64'(l1251), 0);

    // Finish the second frame with gaps, then pulse on the boundary sample.
    sent = 0; i = 0;
    while (sent < FRAME_LEN - 2) begin
      @(negedge clk);
      if (i % 7 == 3) bus.din_val = 0;
      else begin bus.din_val = 1; bus.din = tbl[sent % 8]; sent++; end
      i++;
    end
    @(negedge clk);
    wv = '{-5, -4, 3, 0, 0, 0, 0, 0};
    load_w(); bus.new_weight_val = 1; bus.din = -100; bus.din_val = 1;
    @(negedge clk); bus.new_weight_val = 0; bus.din_val = 0;
    repeat (2) @(negedge clk);
    chk("coincide_val", bus.dout_val, 1);
    chk("coincide_ch0", bus.dout[7:0], 8);
    chk("coincide_ch1", bus.dout[15:8], 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); bus.din_val = 1; bus.din = tbl[k];
    end

    // Reset with samples in flight.
    @(negedge clk); bus.din_val = 0;
    #2 rst_n = 0;
    #1 chk("midrst_val", bus.dout_val, 0);
    repeat (2) @(negedge clk);
    rst_n = 1; bus.din_val = 1; bus.din = 20;
    repeat (6) @(negedge clk);
    chk("midrst_ready", bus.din_ready, 0);
    chk("midrst_no_out", 64'(out_idx), 0);
    bus.din_val = 0;
    wv = '{1, 2, 0, 0, 0, 0, 0, 0};
    pulse();
    probe(64, 1, 2, "after_rst");

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
